// File: rtl/tod_pkg.sv
// Shared constants, field encoding and the 12-hour mapping helper for the
// time-of-day counter.
package tod_pkg;

    localparam int HOUR_W = 5;
    localparam int MS_W   = 6;

    localparam logic [MS_W-1:0]   SEC_MAX  = 6'd59;
    localparam logic [MS_W-1:0]   MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [HOUR_W-1:0] NOON     = 5'd12;

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2,
        FIELD_RSVD = 2'd3
    } field_e;

    // Midnight shows as 12; afternoon hours fold down by twelve.
    function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
        logic [HOUR_W-1:0] r;
        if (h == '0) begin
            r = NOON;
        end else if (h > NOON) begin
            r = h - NOON;
        end else begin
            r = h;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Divides clk down to a one-second tick; tick is high during the wrap cycle
// so the consumer registers the new time on the same edge the divider wraps.
module tick_divider #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int DIV_W         = $clog2(TICKS_PER_SEC)
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICKS_PER_SEC - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_wrap;

    assign w_wrap = run && (r_div_cnt == LAST);
    assign tick   = w_wrap;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (clear) begin
            r_div_cnt <= '0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
        end else if (run) begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tod_counter.sv
// 24-hour binary time-of-day counter with validated field writes,
// a 12-hour display view and a minute-resolution alarm.
module tod_counter
    import tod_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int DIV_W         = $clog2(TICKS_PER_SEC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              mode_12h,
    input  logic              set_valid,
    input  logic [1:0]        set_field,
    input  logic [MS_W-1:0]   set_value,
    output logic              set_ack,
    output logic              set_err,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hours,
    input  logic [MS_W-1:0]   alarm_minutes,
    output logic              alarm,
    output logic              sec_tick,
    output logic [HOUR_W-1:0] hours,
    output logic [MS_W-1:0]   minutes,
    output logic [MS_W-1:0]   seconds,
    output logic [HOUR_W-1:0] disp_hours,
    output logic              pm
);

    logic [HOUR_W-1:0] r_hour;
    logic [MS_W-1:0]   r_min;
    logic [MS_W-1:0]   r_sec;
    logic              r_set_ack;
    logic              r_set_err;
    logic              r_alarm;
    logic              r_sec_tick;

    logic              w_tick;
    logic              w_tick_eff;
    logic              w_set_ok;
    logic              w_set_accept;
    logic              w_set_reject;
    logic              w_alarm_hit;
    field_e            w_field;
    logic [HOUR_W-1:0] w_next_hour;
    logic [MS_W-1:0]   w_next_min;
    logic [MS_W-1:0]   w_next_sec;

    assign w_field = field_e'(set_field);

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned, which
        // would otherwise infer a latch.
        w_set_ok = 1'b0;
        case (w_field)
            FIELD_SEC:  w_set_ok = (set_value <= SEC_MAX);
            FIELD_MIN:  w_set_ok = (set_value <= MIN_MAX);
            FIELD_HOUR: w_set_ok = (set_value <= {1'b0, HOUR_MAX});
            default:    w_set_ok = 1'b0;
        endcase
    end

    assign w_set_accept = set_valid && w_set_ok;
    assign w_set_reject = set_valid && !w_set_ok;
    // An accepted write restarts the second, so a coincident tick is dropped.
    assign w_tick_eff   = w_tick && !w_set_accept;

    always_comb begin
        w_next_sec  = r_sec + 1'b1;
        w_next_min  = r_min;
        w_next_hour = r_hour;
        if (r_sec == SEC_MAX) begin
            w_next_sec = '0;
            w_next_min = r_min + 1'b1;
            if (r_min == MIN_MAX) begin
                w_next_min  = '0;
                w_next_hour = (r_hour == HOUR_MAX) ? '0 : r_hour + 1'b1;
            end
        end
    end

    // Compared against the post-tick time so only a tick can raise the alarm.
    assign w_alarm_hit = alarm_en
                      && (alarm_hours   <= HOUR_MAX)
                      && (alarm_minutes <= MIN_MAX)
                      && (w_next_sec  == '0)
                      && (w_next_min  == alarm_minutes)
                      && (w_next_hour == alarm_hours);

    tick_divider #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .DIV_W         (DIV_W)
    ) u_tick_divider (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (w_set_accept),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hour     <= '0;
            r_min      <= '0;
            r_sec      <= '0;
            r_set_ack  <= 1'b0;
            r_set_err  <= 1'b0;
            r_alarm    <= 1'b0;
            r_sec_tick <= 1'b0;
        end else begin
            r_set_ack  <= w_set_accept;
            r_set_err  <= w_set_reject;
            r_sec_tick <= w_tick_eff;
            r_alarm    <= w_tick_eff && w_alarm_hit;
            if (w_set_accept) begin
                case (w_field)
                    FIELD_SEC:  r_sec  <= set_value;
                    FIELD_MIN:  r_min  <= set_value;
                    FIELD_HOUR: r_hour <= set_value[HOUR_W-1:0];
                    default:    ;
                endcase
            end else if (w_tick_eff) begin
                r_sec  <= w_next_sec;
                r_min  <= w_next_min;
                r_hour <= w_next_hour;
            end
        end
    end

    assign set_ack    = r_set_ack;
    assign set_err    = r_set_err;
    assign alarm      = r_alarm;
    assign sec_tick   = r_sec_tick;
    assign hours      = r_hour;
    assign minutes    = r_min;
    assign seconds    = r_sec;
    assign disp_hours = mode_12h ? to_12h(r_hour) : r_hour;
    assign pm         = (r_hour >= NOON);

endmodule

// File: tb/tb_tod_counter.sv
// Directed bench for tod_counter with a four-cycle second; inputs change and
// outputs are sampled on the falling clock edge.
module tb_tod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mode_12h;
    logic       set_valid;
    logic [1:0] set_field;
    logic [5:0] set_value;
    logic       set_ack;
    logic       set_err;
    logic       alarm_en;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       alarm;
    logic       sec_tick;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [4:0] disp_hours;
    logic       pm;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tod_counter #(.TICKS_PER_SEC(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .mode_12h      (mode_12h),
        .set_valid     (set_valid),
        .set_field     (set_field),
        .set_value     (set_value),
        .set_ack       (set_ack),
        .set_err       (set_err),
        .alarm_en      (alarm_en),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .alarm         (alarm),
        .sec_tick      (sec_tick),
        .hours         (hours),
        .minutes       (minutes),
        .seconds       (seconds),
        .disp_hours    (disp_hours),
        .pm            (pm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_h"}, hours, h);
        check({tag, "_m"}, minutes, m);
        check({tag, "_s"}, seconds, s);
    endtask

    // Three quiet cycles, then the tick cycle.
    task automatic wait_one_sec(input string tag);
        int quiet = 0;
        repeat (3) begin
            @(negedge clk);
            quiet += int'(sec_tick) + int'(alarm);
        end
        check({tag, "_quiet"}, quiet, 0);
        @(negedge clk);
        check({tag, "_tick"}, sec_tick, 1);
    endtask

    task automatic do_set(input string tag, input logic [1:0] f, input logic [5:0] v,
                          input logic ok);
        set_valid = 1'b1;
        set_field = f;
        set_value = v;
        @(negedge clk);
        set_valid = 1'b0;
        check({tag, "_ack"}, set_ack, ok);
        check({tag, "_err"}, set_err, !ok);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int frozen;
        rst           = 1'b1;
        run           = 1'b1;
        mode_12h      = 1'b1;
        set_valid     = 1'b0;
        set_field     = 2'd0;
        set_value     = 6'd0;
        alarm_en      = 1'b0;
        alarm_hours   = 5'd7;
        alarm_minutes = 6'd30;

        repeat (2) @(negedge clk);
        check_time("rst", 0, 0, 0);
        check("rst_tick", sec_tick, 0);
        check("rst_ack", set_ack, 0);
        check("rst_err", set_err, 0);
        check("rst_alarm", alarm, 0);
        check("rst_disp12", disp_hours, 12);
        check("rst_pm", pm, 0);

        rst = 1'b0;
        wait_one_sec("free1");
        check_time("free1", 0, 0, 1);
        wait_one_sec("free2");
        check_time("free2", 0, 0, 2);

        do_set("roll_h", 2'd2, 6'd23, 1'b1);
        do_set("roll_m", 2'd1, 6'd59, 1'b1);
        do_set("roll_s", 2'd0, 6'd59, 1'b1);
        check_time("roll_pre", 23, 59, 59);
        wait_one_sec("roll");
        check_time("roll", 0, 0, 0);

        do_set("mid_h", 2'd2, 6'd10, 1'b1);
        do_set("mid_m", 2'd1, 6'd59, 1'b1);
        do_set("mid_s", 2'd0, 6'd59, 1'b1);
        wait_one_sec("mid");
        check_time("mid", 11, 0, 0);

        // Three rejected writes leave the divider running; the fourth write
        // lands on the wrap cycle.
        do_set("bad_s60", 2'd0, 6'd60, 1'b0);
        check("bad_s60_val", seconds, 0);
        do_set("bad_h24", 2'd2, 6'd24, 1'b0);
        check("bad_h24_val", hours, 11);
        do_set("bad_rsvd", 2'd3, 6'd5, 1'b0);
        check_time("bad_rsvd", 11, 0, 0);
        do_set("ok_m42", 2'd1, 6'd42, 1'b1);
        check("ok_m42_tick", sec_tick, 0);
        check_time("ok_m42", 11, 42, 0);
        wait_one_sec("post_set");
        check_time("post_set", 11, 42, 1);

        do_set("col_s59", 2'd0, 6'd59, 1'b1);
        repeat (3) @(negedge clk);
        do_set("col_s10", 2'd0, 6'd10, 1'b1);
        check("col_tick", sec_tick, 0);
        check_time("col", 11, 42, 10);
        wait_one_sec("col_next");
        check_time("col_next", 11, 42, 11);

        do_set("v12_0", 2'd2, 6'd0, 1'b1);
        check("v12_0_disp", disp_hours, 12);
        check("v12_0_pm", pm, 0);
        do_set("v12_12", 2'd2, 6'd12, 1'b1);
        check("v12_12_disp", disp_hours, 12);
        check("v12_12_pm", pm, 1);
        do_set("v12_13", 2'd2, 6'd13, 1'b1);
        check("v12_13_disp", disp_hours, 1);
        check("v12_13_pm", pm, 1);
        do_set("v12_23", 2'd2, 6'd23, 1'b1);
        check("v12_23_disp", disp_hours, 11);
        check("v12_23_pm", pm, 1);
        mode_12h = 1'b0;
        #1;
        check("v24_23_disp", disp_hours, 23);
        check("v24_23_pm", pm, 1);
        mode_12h = 1'b1;

        // Divider reaches phase 2, freezes for 20 cycles, then resumes.
        repeat (2) @(negedge clk);
        run    = 1'b0;
        frozen = 0;
        repeat (20) begin
            @(negedge clk);
            frozen += int'(sec_tick);
        end
        check("pause_ticks", frozen, 0);
        check_time("pause", 23, 42, 11);
        run = 1'b1;
        @(negedge clk);
        check("resume_quiet", sec_tick, 0);
        @(negedge clk);
        check("resume_tick", sec_tick, 1);
        check_time("resume", 23, 42, 12);

        alarm_en = 1'b1;
        do_set("al_h", 2'd2, 6'd7, 1'b1);
        do_set("al_m", 2'd1, 6'd29, 1'b1);
        do_set("al_s", 2'd0, 6'd59, 1'b1);
        wait_one_sec("al");
        check("al_fire", alarm, 1);
        check_time("al", 7, 30, 0);
        wait_one_sec("al_next");
        check("al_next_fire", alarm, 0);

        alarm_en = 1'b0;
        do_set("dis_m", 2'd1, 6'd29, 1'b1);
        do_set("dis_s", 2'd0, 6'd59, 1'b1);
        wait_one_sec("dis");
        check("dis_fire", alarm, 0);
        check_time("dis", 7, 30, 0);

        alarm_en = 1'b1;
        do_set("dir_m", 2'd1, 6'd29, 1'b1);
        do_set("dir_s", 2'd0, 6'd0, 1'b1);
        do_set("dir_m30", 2'd1, 6'd30, 1'b1);
        check("dir_fire", alarm, 0);
        alarm_minutes = 6'd31;
        @(negedge clk);
        alarm_minutes = 6'd30;
        @(negedge clk);
        check("chg_fire", alarm, 0);

        do_set("pre_rst", 2'd1, 6'd15, 1'b1);
        rst = 1'b1;
        #1;
        check_time("mid_rst", 0, 0, 0);
        check("mid_rst_ack", set_ack, 0);
        check("mid_rst_tick", sec_tick, 0);
        check("mid_rst_alarm", alarm, 0);
        check("mid_rst_disp", disp_hours, 12);
        check("mid_rst_pm", pm, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_one_sec("after_rst");
        check_time("after_rst", 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
